// File: rtl/sr_drv_pkg.sv
// Shared types for the SR excitation driver: FSM state encoding, the per-bit
// S/R excitation pair and the "hold" excitation that leaves a flop untouched.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  typedef struct packed {
    logic s;
    logic r;
  } sr_exc_t;

  // S=0,R=0: the flop keeps its present value.
  localparam sr_exc_t SR_HOLD = '{s: 1'b0, r: 1'b0};

endpackage

// File: rtl/sr_excitation_driver_if.sv
// Bus between the write source / SR bank and the driver.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
// the source keeps in_valid and in_data stable until that edge, and in_valid
// seen while in_ready is low is ignored (nothing is queued). done/err are
// single-cycle result pulses. state_dbg mirrors the driver FSM for observation.
interface sr_excitation_driver_if #(
  parameter int WIDTH = 8,
  parameter int RC_W  = 2
);
  import sr_drv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q_fb;
  logic             done;
  logic             err;
  logic             busy;
  logic [RC_W-1:0]  retry_cnt;
  state_t           state_dbg;

  modport slave (
    input  in_valid, in_data, q_fb,
    output in_ready, s, r, done, err, busy, retry_cnt, state_dbg
  );

  modport master (
    output in_valid, in_data, q_fb,
    input  in_ready, s, r, done, err, busy, retry_cnt, state_dbg
  );

endinterface

// File: rtl/sr_excite_enc.sv
// Per-bit SR excitation encoder: bits that already hold the target get
// S=R=0; a 0->1 bit gets S, a 1->0 bit gets R. S=R=1 is never produced.
module sr_excite_enc
  import sr_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] snap,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  sr_exc_t exc;

  // Excitation table applied bit by bit.
  always_comb begin
    s   = '0;
    r   = '0;
    exc = SR_HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      exc  = (tgt[i] == snap[i]) ? SR_HOLD : '{s: tgt[i], r: snap[i]};
      s[i] = exc.s;
      r[i] = exc.r;
    end
  end

endmodule

// File: rtl/sr_excitation_driver.sv
// Write-side controller for a bank of SR flops. Accepts a target word, drives
// S/R excitation derived from the bank's present state for HOLD_CYCLES,
// idles S/R for one settle cycle, reads the bank back and reports done/err.
// Optional feature macro: SR_DRV_RETRY_EN enables up to MAX_RETRY re-attempts
// after a readback mismatch; without it a mismatch raises err at once and
// retry_cnt stays 0.
module sr_excitation_driver
  import sr_drv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sr_excitation_driver_if.slave bus
);

  localparam int RC_W = $clog2(MAX_RETRY + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic [HC_W-1:0]  hold_cnt;
  logic [RC_W-1:0]  retry_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] r_q;
  logic             done_q;
  logic             err_q;
  logic             busy_q;

  logic [WIDTH-1:0] enc_tgt;
  logic [WIDTH-1:0] enc_s;
  logic [WIDTH-1:0] enc_r;

  // The snapshot of the bank is taken on the edge that loads S/R (accept or
  // retry), so the encoder sees q_fb live; in IDLE the target is in_data.
  assign enc_tgt = (state == IDLE) ? bus.in_data : tgt;

  sr_excite_enc #(.WIDTH(WIDTH)) u_enc (
    .tgt  (enc_tgt),
    .snap (bus.q_fb),
    .s    (enc_s),
    .r    (enc_r)
  );

  // Main FSM with hold counter, retry counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= '0;
      hold_cnt <= '0;
      retry_q  <= '0;
      s_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            tgt      <= bus.in_data;
            retry_q  <= '0;
            s_q      <= enc_s;
            r_q      <= enc_r;
            hold_cnt <= HOLD_INIT;
            busy_q   <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) begin
            s_q   <= '0;
            r_q   <= '0;
            state <= SETTLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        SETTLE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (bus.q_fb == tgt) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
`ifdef SR_DRV_RETRY_EN
            if (retry_q < RC_W'(MAX_RETRY)) begin
              retry_q  <= retry_q + 1'b1;
              s_q      <= enc_s;
              r_q      <= enc_r;
              hold_cnt <= HOLD_INIT;
              state    <= DRIVE;
            end else begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
`else
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_dbg = state;

  // A flop must never see S and R together.
  a_no_sr_both : assert property (@(posedge clk) disable iff (rst) (s_q & r_q) == '0);

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Bench for sr_excitation_driver (WIDTH=8, HOLD_CYCLES=2, MAX_RETRY=3).
// The SR bank is a behavioural model with an optional stuck-at-0 mask.
// Expected results are pushed to exp_q at accept and popped at done/err.
module tb_sr_excitation_driver;
  import sr_drv_pkg::*;

  localparam int WIDTH = 8;
  localparam int RC_W  = 2;
  localparam int RW    = 8 + 1 + 1 + RC_W + WIDTH;  // {k, done, err, rc, q}

`ifdef SR_DRV_RETRY_EN
  localparam int EXP_RETRIES = 3;
`else
  localparam int EXP_RETRIES = 0;
`endif

  typedef struct {
    logic [7:0] bank;
    logic [7:0] stuck0;
    logic [7:0] tgt;
    logic [7:0] exp_s;
    logic [7:0] exp_r;
    int         exp_k;
    logic       exp_done;
    logic       exp_err;
    logic [1:0] exp_rc;
    logic [7:0] exp_q;
    logic       poke;
  } vec_t;

  logic clk;
  logic rst;
  sr_excitation_driver_if #(.WIDTH(WIDTH), .RC_W(RC_W)) bus ();

  sr_excitation_driver #(.WIDTH(WIDTH), .HOLD_CYCLES(2), .MAX_RETRY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SR bank model ----------------
  logic [7:0] bank;
  logic [7:0] stuck0;
  logic       load_en;
  logic [7:0] load_val;

  always @(posedge clk) begin
    if (load_en) bank <= load_val;
    else         bank <= (bank & ~bus.r) | bus.s;
  end
  assign bus.q_fb = bank & ~stuck0;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_bank(input logic [7:0] val, input logic [7:0] stk);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = val;
    stuck0   = stk;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int         k;
    int         inv_bad;
    logic       got;
    logic [RW-1:0] exp_w;
    logic [RW-1:0] act_w;
    load_bank(v.bank, v.stuck0);
    check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v.tgt;
    exp_q.push_back({8'(v.exp_k), v.exp_done, v.exp_err, v.exp_rc, v.exp_q});
    @(posedge clk);
    @(negedge clk);
    k = 0;
    bus.in_valid = v.poke;
    bus.in_data  = ~v.tgt;
    check({tag, " s"}, {24'd0, bus.s}, {24'd0, v.exp_s});
    check({tag, " r"}, {24'd0, bus.r}, {24'd0, v.exp_r});
    inv_bad = 0;
    got = 1'b0;
    while (k < 64) begin
      if ((bus.s & bus.r) != 8'h00) inv_bad++;
      if (bus.done || bus.err) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    bus.in_valid = 1'b0;
    check({tag, " s&r==0"}, inv_bad, 0);
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done/err within %0d cycles", tag, k);
      void'(exp_q.pop_front());
    end else begin
      exp_w = exp_q.pop_front();
      act_w = {8'(k), bus.done, bus.err, bus.retry_cnt, bus.q_fb};
      check({tag, " result{k,done,err,rc,q}"}, 32'(act_w), 32'(exp_w));
      check({tag, " in_ready after"}, {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      check({tag, " pulse width"}, {30'd0, bus.done, bus.err}, 32'd0);
    end
  endtask

  function automatic vec_t clean_vec(input logic [7:0] b, input logic [7:0] t, input logic p);
    vec_t v;
    v.bank = b; v.stuck0 = 8'h00; v.tgt = t;
    v.exp_s = t & ~b; v.exp_r = ~t & b;
    v.exp_k = 4; v.exp_done = 1'b1; v.exp_err = 1'b0; v.exp_rc = 2'd0;
    v.exp_q = t; v.poke = p;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs[8];
  vec_t stuck_v;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    load_en  = 1'b1;
    load_val = 8'h00;
    stuck0   = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset s", {24'd0, bus.s}, 32'd0);
    check("reset r", {24'd0, bus.r}, 32'd0);
    check("reset done/err/busy", {29'd0, bus.done, bus.err, bus.busy}, 32'd0);
    check("reset retry_cnt", {30'd0, bus.retry_cnt}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset state", {30'd0, bus.state_dbg}, {30'd0, IDLE});
    rst = 1'b0;
    load_en = 1'b0;

    // Vector table
    vecs[0] = clean_vec(8'h00, 8'hA5, 1'b0);
    vecs[1] = clean_vec(8'hF0, 8'h0F, 1'b0);
    vecs[2] = clean_vec(8'h3C, 8'h3C, 1'b0);
    vecs[3] = clean_vec(8'h5A, 8'hC3, 1'b1);
    vecs[3].exp_s = 8'h81;
    vecs[3].exp_r = 8'h18;
    for (int i = 4; i < 8; i++)
      vecs[i] = clean_vec(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // Bit 0 stuck at 0, write 0x01
    stuck_v.bank = 8'h00; stuck_v.stuck0 = 8'h01; stuck_v.tgt = 8'h01;
    stuck_v.exp_s = 8'h01; stuck_v.exp_r = 8'h00;
    stuck_v.exp_k = 4 * (1 + EXP_RETRIES);
    stuck_v.exp_done = 1'b0; stuck_v.exp_err = 1'b1;
    stuck_v.exp_rc = 2'(EXP_RETRIES); stuck_v.exp_q = 8'h00; stuck_v.poke = 1'b0;
    run_op(stuck_v, "stuck");
    stuck0 = 8'h00;

    // Reset during DRIVE of 0xFF
    load_bank(8'h00, 8'h00);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rstmid drive s", {24'd0, bus.s}, 32'h0000_00FF);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid s/r", {16'd0, bus.s, bus.r}, 32'd0);
    check("rstmid busy/done/err", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    check("rstmid in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid in_ready after", {31'd0, bus.in_ready}, 32'd1);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        if (bus.done || bus.err || bus.busy) pulses++;
        @(negedge clk);
      end
      check("rstmid no done/err/busy", pulses, 0);
    end
    run_op(clean_vec(8'hFF, 8'h12, 1'b1), "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
